// File: rtl/pwm_led_fader_if.sv
// Configuration port for pwm_led_fader.
// Carries a valid/ready request that selects a channel, a mode and a duty.
// The master presents the request and the fader (slave) answers with cfg_ready.
interface pwm_led_fader_if #(
  parameter int CHANNELS = 3,
  parameter int WIDTH    = 8
);
  localparam int CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic              cfg_valid;
  logic              cfg_ready;
  logic [CHAN_W-1:0] cfg_chan;
  logic [1:0]        cfg_mode;
  logic [WIDTH-1:0]  cfg_duty;

  modport master (
    output cfg_valid,
    output cfg_chan,
    output cfg_mode,
    output cfg_duty,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_chan,
    input  cfg_mode,
    input  cfg_duty,
    output cfg_ready
  );
endinterface

// File: rtl/pwm_led_fader.sv
// Multi-channel PWM LED driver with active-low outputs and a per-channel
// breathe (fade) mode.
// New configuration is held in a single pending slot and applied only at a
// PWM period boundary, so a channel never changes duty mid-period.
// Optional feature: define PWM_LED_FADER_GAMMA_EN to compare the PWM counter
// against a squared (gamma-corrected) duty instead of the linear duty.
module pwm_led_fader #(
  parameter int CHANNELS     = 3,
  parameter int WIDTH        = 8,
  parameter int PRESCALE     = 47,
  parameter int FADE_PERIODS = 4
) (
  input  logic                clk,
  input  logic                rst,
  pwm_led_fader_if.slave      cfg,
  output logic                period_tick,
  output logic [CHANNELS-1:0] nled
);

  localparam int CHAN_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PRESC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int FADE_W  = (FADE_PERIODS > 1) ? $clog2(FADE_PERIODS) : 1;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESCALE - 1);
  localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);
  localparam logic [FADE_W-1:0]  FADE_LAST  = FADE_W'(FADE_PERIODS - 1);
  localparam logic [FADE_W-1:0]  FADE_ONE   = FADE_W'(1);
  localparam logic [WIDTH-1:0]   CNT_LAST   = '1;
  localparam logic [WIDTH-1:0]   DUTY_ONE   = WIDTH'(1);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_STATIC  = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_t;

  typedef enum logic {
    FADE_UP   = 1'b0,
    FADE_DOWN = 1'b1
  } fade_t;

  logic [PRESC_W-1:0] presc;
  logic [WIDTH-1:0]   cnt;
  logic               step;
  logic               wrap;

  logic               pending;
  logic [CHAN_W-1:0]  pend_chan;
  mode_t              pend_mode;
  logic [WIDTH-1:0]   pend_duty;

  logic [CHANNELS-1:0] breathe_on;
  logic [WIDTH-1:0]    active_duty [CHANNELS];
  logic [WIDTH-1:0]    peak_duty   [CHANNELS];
  fade_t               fade_state  [CHANNELS];
  logic [FADE_W-1:0]   fade_cnt    [CHANNELS];
  logic [WIDTH-1:0]    cmp_duty    [CHANNELS];

  assign step          = (presc == PRESC_LAST);
  assign wrap          = step && (cnt == CNT_LAST);
  assign cfg.cfg_ready = ~pending;

  // Prescaler: divides the system clock down to one PWM counter step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else if (step) begin
      presc <= '0;
    end else begin
      presc <= presc + PRESC_ONE;
    end
  end

  // PWM counter advances once per prescaler step and wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (step) begin
      cnt <= cnt + DUTY_ONE;
    end
  end

  // Period tick is the registered wrap strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_tick <= 1'b0;
    end else begin
      period_tick <= wrap;
    end
  end

  // Config slot plus per-channel breathe FSMs; everything changes only at wrap
  // except the capture of a new request into the empty pending slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending    <= 1'b0;
      pend_chan  <= '0;
      pend_mode  <= MODE_OFF;
      pend_duty  <= '0;
      breathe_on <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        active_duty[i] <= '0;
        peak_duty[i]   <= '0;
        fade_state[i]  <= FADE_UP;
        fade_cnt[i]    <= '0;
      end
    end else begin
      if (cfg.cfg_valid && !pending) begin
        if (int'(cfg.cfg_chan) < CHANNELS) begin
          pending   <= 1'b1;
          pend_chan <= cfg.cfg_chan;
          pend_mode <= mode_t'(cfg.cfg_mode);
          pend_duty <= cfg.cfg_duty;
        end
      end
      if (wrap) begin
        if (pending) begin
          pending <= 1'b0;
        end
        for (int i = 0; i < CHANNELS; i++) begin
          if (pending && (int'(pend_chan) == i)) begin
            case (pend_mode)
              MODE_STATIC: begin
                breathe_on[i]  <= 1'b0;
                active_duty[i] <= pend_duty;
              end
              MODE_BREATHE: begin
                breathe_on[i]  <= 1'b1;
                peak_duty[i]   <= pend_duty;
                active_duty[i] <= '0;
                fade_state[i]  <= FADE_UP;
                fade_cnt[i]    <= '0;
              end
              default: begin
                breathe_on[i]  <= 1'b0;
                active_duty[i] <= '0;
              end
            endcase
          end else if (breathe_on[i]) begin
            if (fade_cnt[i] == FADE_LAST) begin
              fade_cnt[i] <= '0;
              if (fade_state[i] == FADE_UP) begin
                if (active_duty[i] < peak_duty[i]) begin
                  active_duty[i] <= active_duty[i] + DUTY_ONE;
                  if ((active_duty[i] + DUTY_ONE) == peak_duty[i]) begin
                    fade_state[i] <= FADE_DOWN;
                  end
                end
              end else begin
                if (active_duty[i] != '0) begin
                  active_duty[i] <= active_duty[i] - DUTY_ONE;
                  if (active_duty[i] == DUTY_ONE) begin
                    fade_state[i] <= FADE_UP;
                  end
                end
              end
            end else begin
              fade_cnt[i] <= fade_cnt[i] + FADE_ONE;
            end
          end
        end
      end
    end
  end

  // Compare value per channel: linear duty, or its square scaled back to WIDTH bits.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
`ifdef PWM_LED_FADER_GAMMA_EN
      cmp_duty[i] = WIDTH'(({{WIDTH{1'b0}}, active_duty[i]} *
                            {{WIDTH{1'b0}}, active_duty[i]}) >> WIDTH);
`else
      cmp_duty[i] = active_duty[i];
`endif
    end
  end

  // Registered active-low LED drive: lit while the counter is below the compare value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nled <= '1;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        nled[i] <= ~(cnt < cmp_duty[i]);
      end
    end
  end

endmodule
